// File: rtl/sreg_tx.sv
// Serial address transmitter: shifts a parallel address MSB-first into the remote
// shift-register receiver, or issues a single counter pulse. Optional macro: SREG_TX_SHADOW_EN.
module sreg_tx #(
    parameter int ADDR_WIDTH = 21,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  incr,
    output logic                  busy,
    output logic                  done,
    output logic                  sreg_clk,
    output logic                  sreg_si,
    output logic                  sreg_en_n,
    output logic                  sreg_counter_n
`ifdef SREG_TX_SHADOW_EN
    ,
    output logic [ADDR_WIDTH-1:0] shadow_addr
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADDR_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        INC_SETUP,
        INC_HI,
        INC_LO
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DIV_W-1:0]      div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [ADDR_WIDTH-1:0] shreg;
    logic                  phase_end;
    logic                  accept_start;
    logic                  advance_bit;

    assign phase_end    = (div_cnt == DIV_LAST);
    assign accept_start = (state == IDLE) && start;
    assign advance_bit  = (state == SHIFT_HI) && (next_state == SHIFT_LO);

    // The data line is the MSB of the shift register, so it is a registered output.
    assign sreg_si = shreg[ADDR_WIDTH-1];

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SETUP;
                end else if (incr) begin
                    next_state = INC_SETUP;
                end
            end
            SETUP:     if (phase_end) next_state = SHIFT_HI;
            // The last bit's low phase is spent in HOLD, so no extra clock edge follows it.
            SHIFT_HI:  if (phase_end) next_state = (bit_cnt == BIT_LAST) ? HOLD : SHIFT_LO;
            SHIFT_LO:  if (phase_end) next_state = SHIFT_HI;
            HOLD:      if (phase_end) next_state = IDLE;
            INC_SETUP: if (phase_end) next_state = INC_HI;
            INC_HI:    if (phase_end) next_state = INC_LO;
            INC_LO:    if (phase_end) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // NOTE: all state in clocked blocks uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sreg_clk       <= 1'b0;
            sreg_en_n      <= 1'b1;
            sreg_counter_n <= 1'b1;
        end else begin
            state <= next_state;

            if ((next_state != state) || (state == IDLE)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Outputs are decoded from next_state so they change on the same edge as the state.
            busy           <= (next_state != IDLE);
            done           <= (state != IDLE) && (next_state == IDLE);
            sreg_clk       <= (next_state inside {SHIFT_HI, INC_HI});
            sreg_en_n      <= !(next_state inside {SETUP, SHIFT_HI, SHIFT_LO, HOLD});
            sreg_counter_n <= !(next_state inside {INC_SETUP, INC_HI, INC_LO});

            if (accept_start) begin
                shreg   <= addr;
                bit_cnt <= '0;
            end else if (advance_bit) begin
                shreg <= shreg << 1;
                if (bit_cnt != BIT_LAST) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (next_state == IDLE) begin
                shreg <= '0;
            end
        end
    end

`ifdef SREG_TX_SHADOW_EN
    logic [ADDR_WIDTH-1:0] addr_q;

    // Tracks what the receiver should now hold: a fresh load or the previous value plus one.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            shadow_addr <= '0;
        end else begin
            if (accept_start) begin
                addr_q <= addr;
            end
            if ((state == HOLD) && (next_state == IDLE)) begin
                shadow_addr <= addr_q;
            end else if ((state == INC_LO) && (next_state == IDLE)) begin
                shadow_addr <= shadow_addr + 1'b1;
            end
        end
    end
`endif

endmodule
